// File: rtl/pc_int_unit_if.sv
// Signal bundle between the core's instruction sequencer and pc_int_unit.
// The master drives the boundary strobes and the interrupt request; the slave returns PC and status.
interface pc_int_unit_if #(
  parameter int XLEN      = 32,
  parameter int STK_DEPTH = 4
);
  localparam int DW = $clog2(STK_DEPTH + 1);

  logic            INT;
  logic            updPC;
  logic            isBranch;
  logic [XLEN-1:0] br_target;
  logic            is_reti;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] NPC;
  logic            int_ack;
  logic            int_active;
  logic [DW-1:0]   stk_depth;
  logic            stk_unf;

  modport master (
    output INT, updPC, isBranch, br_target, is_reti,
    input  PC, NPC, int_ack, int_active, stk_depth, stk_unf
  );

  modport slave (
    input  INT, updPC, isBranch, br_target, is_reti,
    output PC, NPC, int_ack, int_active, stk_depth, stk_unf
  );
endinterface

// File: rtl/pc_int_unit.sv
// Program-counter sequencer with vectored interrupt entry and a return-address stack.
// Define INT_NEST_EN to let interrupts nest up to STK_DEPTH; otherwise only one is serviced at a time.
module pc_int_unit #(
  parameter int              XLEN      = 32,
  parameter longint unsigned RST_VEC   = 0,
  parameter longint unsigned INT_VEC   = 64'h0000_0100,
  parameter longint unsigned PC_STEP   = 1,
  parameter int              STK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_int_unit_if.slave bus
);
  localparam int              DW     = $clog2(STK_DEPTH + 1);
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RST_VEC);
  localparam logic [XLEN-1:0] INT_PC = XLEN'(INT_VEC);
  localparam logic [XLEN-1:0] STEP   = XLEN'(PC_STEP);
  localparam logic [DW-1:0]   FULL   = DW'(STK_DEPTH);
  localparam logic [DW-1:0]   ONE    = DW'(1);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [DW-1:0]   depth_reg, depth_next;
  logic            sync1_reg, sync2_reg, sync3_reg;
  logic            pending_reg, pending_next;
  logic            ack_reg, ack_next;
  logic            unf_reg, unf_next;
  logic            int_edge, allowed, do_push;
  logic [XLEN-1:0] npc, seq_next, top_val;
  logic [XLEN-1:0] stack_q [STK_DEPTH];

  // Each entry only ever captures the return address when it is the next free slot.
  for (genvar gi = 0; gi < STK_DEPTH; gi++) begin : g_stk
    logic [XLEN-1:0] entry_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_reg <= '0;
      end else if (do_push && depth_reg == DW'(gi)) begin
        entry_reg <= seq_next;
      end
    end
    assign stack_q[gi] = entry_reg;
  end

  always_comb begin
    top_val = '0;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (depth_reg == DW'(i + 1)) top_val = stack_q[i];
    end
  end

  assign npc      = pc_reg + STEP;
  assign seq_next = bus.isBranch ? bus.br_target : npc;
  assign int_edge = sync2_reg & ~sync3_reg;

`ifdef INT_NEST_EN
  assign allowed = (depth_reg < FULL);
`else
  assign allowed = (depth_reg == '0);
`endif

  // Priority at a boundary: return, underflowing return, interrupt entry, sequential/branch.
  always_comb begin
    pc_next      = pc_reg;
    depth_next   = depth_reg;
    pending_next = pending_reg | int_edge;
    ack_next     = 1'b0;
    unf_next     = unf_reg;
    do_push      = 1'b0;
    if (bus.updPC) begin
      if (bus.is_reti && depth_reg != '0) begin
        pc_next    = top_val;
        depth_next = depth_reg - ONE;
      end else if (bus.is_reti) begin
        pc_next  = seq_next;
        unf_next = 1'b1;
      end else if (pending_reg && allowed) begin
        do_push      = 1'b1;
        pc_next      = INT_PC;
        depth_next   = depth_reg + ONE;
        pending_next = int_edge;
        ack_next     = 1'b1;
      end else begin
        pc_next = seq_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg      <= RST_PC;
      depth_reg   <= '0;
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync3_reg   <= 1'b0;
      pending_reg <= 1'b0;
      ack_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      depth_reg   <= depth_next;
      sync1_reg   <= bus.INT;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      pending_reg <= pending_next;
      ack_reg     <= ack_next;
      unf_reg     <= unf_next;
    end
  end

  assign bus.PC         = pc_reg;
  assign bus.NPC        = npc;
  assign bus.int_ack    = ack_reg;
  assign bus.int_active = (depth_reg != '0);
  assign bus.stk_depth  = depth_reg;
  assign bus.stk_unf    = unf_reg;
endmodule

// File: tb/tb_pc_int_unit.sv
// Scoreboard bench for pc_int_unit: a queue-based reference model predicts every clock edge,
// a monitor compares the DUT one time step after each rising edge.
module tb_pc_int_unit;
  localparam int          XLEN = 32;
  localparam int          D    = 2;
  localparam logic [31:0] RSTV = 32'h0;
  localparam logic [31:0] INTV = 32'h100;
  localparam logic [31:0] STEP = 32'h1;
`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_int_unit_if #(.XLEN(XLEN), .STK_DEPTH(D)) bus ();

  pc_int_unit #(
    .XLEN(XLEN), .RST_VEC(0), .INT_VEC(64'h100), .PC_STEP(1), .STK_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    bit          ack;
    int          depth;
    bit          unf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          txn    = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_pend, m_unf, m_ack;
  bit          m_hist[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit model_allowed();
    return NEST ? (m_stk.size() < D) : (m_stk.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc   = RSTV;
    m_stk.delete();
    m_pend = 1'b0;
    m_unf  = 1'b0;
    m_ack  = 1'b0;
    m_hist = '{1'b0, 1'b0, 1'b0};
  endtask

  // A level held on INT at edge c-2 but not c-3 marks pending after edge c.
  task automatic model_step();
    bit          edge_seen;
    logic [31:0] seq;
    exp_t        e;
    m_hist.push_back(bus.INT);
    edge_seen = m_hist[m_hist.size()-3] && !m_hist[m_hist.size()-4];
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    m_ack = 1'b0;
    seq   = bus.isBranch ? bus.br_target : m_pc + STEP;
    if (bus.updPC) begin
      if (bus.is_reti && m_stk.size() > 0) begin
        m_pc = m_stk.pop_back();
      end else if (bus.is_reti) begin
        m_pc  = seq;
        m_unf = 1'b1;
      end else if (m_pend && model_allowed()) begin
        m_stk.push_back(seq);
        m_pc   = INTV;
        m_pend = 1'b0;
        m_ack  = 1'b1;
      end else begin
        m_pc = seq;
      end
    end
    m_pend  = m_pend | edge_seen;
    e.pc    = m_pc;
    e.ack   = m_ack;
    e.depth = m_stk.size();
    e.unf   = m_unf;
    sb.push_back(e);
  endtask

  task automatic step(bit i, bit u, bit b, logic [31:0] t, bit r);
    @(negedge clk);
    bus.INT       = i;
    bus.updPC     = u;
    bus.isBranch  = b;
    bus.br_target = t;
    bus.is_reti   = r;
    model_step();
  endtask

  // Reset lands between edges; its effect is checked before any clock can act.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst           = 1'b0;
    bus.INT       = 1'b0;
    bus.updPC     = 1'b0;
    bus.isBranch  = 1'b0;
    bus.br_target = '0;
    bus.is_reti   = 1'b0;
    #1;
    check("rst_pc", bus.PC, RSTV);
    check("rst_npc", bus.NPC, RSTV + STEP);
    check("rst_depth", 32'(bus.stk_depth), 32'd0);
    check("rst_active", 32'(bus.int_active), 32'd0);
    check("rst_ack", 32'(bus.int_ack), 32'd0);
    check("rst_unf", 32'(bus.stk_unf), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    model_step();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && sb.size() > 0) begin
      e = sb.pop_front();
      check("pc", bus.PC, e.pc);
      check("npc", bus.NPC, e.pc + STEP);
      check("int_ack", 32'(bus.int_ack), 32'(e.ack));
      check("stk_depth", 32'(bus.stk_depth), 32'(e.depth));
      check("int_active", 32'(bus.int_active), 32'(e.depth != 0));
      check("stk_unf", 32'(bus.stk_unf), 32'(e.unf));
      $display("txn %0d pc=%h depth=%0d ack=%b unf=%b", txn, bus.PC, bus.stk_depth,
               bus.int_ack, bus.stk_unf);
      txn++;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    do_reset();
    repeat (3) step(0, 1, 0, '0, 0);
    repeat (2) step(0, 0, 0, '0, 0);
    step(0, 1, 1, 32'h40, 0);

    // Single interrupt, then return.
    step(1, 1, 0, '0, 0);
    repeat (5) step(0, 1, 0, '0, 0);
    step(0, 1, 0, '0, 1);

    // Interrupt taken at a branching boundary; further requests pile up.
    step(1, 1, 0, '0, 0);
    for (int k = 0; k < 8 && !m_ack; k++) begin
      if (m_pend && model_allowed()) step(0, 1, 1, 32'h80, 0);
      else step(0, 1, 0, '0, 0);
    end
    for (int n = 0; n < 2; n++) begin
      step(1, 1, 0, '0, 0);
      repeat (5) step(0, 1, 0, '0, 0);
    end
    step(0, 1, 0, '0, 1);
    repeat (3) step(0, 1, 0, '0, 0);
    for (int k = 0; k < 12 && (m_stk.size() > 0 || m_pend); k++)
      step(0, 1, 0, '0, m_stk.size() > 0);

    // Underflowing return, then stickiness.
    step(0, 1, 1, 32'd10, 0);
    step(0, 1, 0, '0, 1);
    repeat (3) step(0, 1, 0, '0, 0);

    // PC wrap.
    step(0, 1, 1, 32'hFFFF_FFFF, 0);
    step(0, 1, 0, '0, 0);

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom, $urandom_range(0, 5) == 0);

    // Reset while servicing with another request pending.
    do_reset();
    step(1, 1, 0, '0, 0);
    for (int k = 0; k < 10 && m_stk.size() == 0; k++) step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    repeat (4) step(0, 0, 0, '0, 0);
    do_reset();
    repeat (10) step(0, 1, 0, '0, 0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_int_unit.md
Name: pc_int_unit

Overview:
Parametrised program-counter sequencer with vectored interrupt support for the RISC core. It replaces the plain PC register and incrementer pair.
- Selects the next PC from three sources: sequential, branch target, or interrupt vector.
- Synchronises and latches the INT request.
- Saves return addresses on an internal hardware stack with configurable depth.
- Restores PC on return-from-interrupt.

Parameters:
XLEN, 32, PC/address width in bits
RST_VEC, 0, PC value loaded on reset
INT_VEC, 32'h0000_0100, PC loaded when an interrupt is taken (truncated to XLEN)
PC_STEP, 1, sequential increment added to PC
STK_DEPTH, 4, number of return-address stack entries (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
INT  in  1  external interrupt request, asynchronous level; a rising edge requests service
updPC  in  1  instruction-boundary strobe; PC changes only when this is 1
isBranch  in  1  take br_target this boundary
br_target  in  XLEN  branch/jump target from the ALU
is_reti  in  1  current instruction is a return-from-interrupt
PC  out  XLEN  current program counter
NPC  out  XLEN  PC + PC_STEP (combinational, wraps mod 2^XLEN)
int_ack  out  1  one-cycle pulse on the cycle an interrupt is taken
int_active  out  1  1 while the stack depth is > 0
stk_depth  out  $clog2(STK_DEPTH+1)  current number of stack entries
stk_unf  out  1  sticky flag: is_reti occurred with an empty stack

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RST_VEC, stack depth=0, pending=0, synchroniser flops=0.
  - int_ack=0, stk_unf=0; all stack entries cleared to 0.
  - Reset asserted mid-operation drops any pending interrupt and clears all saved return addresses.
- INT path:
  - Two-flop synchroniser, then a rising-edge detector on the synchronised signal.
  - A detected edge sets pending=1.
  - Pending stays set until the interrupt is taken.
  - Further edges while pending are absorbed (no counting).
  - Minimum latency: an INT edge before clk edge n can make pending=1 after edge n+2; it is taken at the first updPC=1 edge after that.
- seq_next = isBranch ? br_target : NPC.
- Rising clk edge with updPC=0: PC, stack and pending hold. int_ack=0. Pending may still be set.
- Rising clk edge with updPC=1, first matching priority wins:
  1. is_reti=1, depth>0: PC<=stack[top]; depth-1. Any pending interrupt stays pending and is evaluated at the next boundary, so no back-to-back service is possible in the same cycle.
  2. is_reti=1, depth=0: PC<=seq_next; stk_unf<=1 (sticky until reset).
  3. pending=1 and interrupt allowed: stack[depth]<=seq_next; depth+1; PC<=INT_VEC; pending<=0; int_ack=1 for this cycle only.
  4. Otherwise: PC<=seq_next.
- Interrupt allowed: depth<STK_DEPTH, subject to the INT_NEST_EN rule below.
- Stack full (depth=STK_DEPTH): the interrupt is not taken and pending is held. There is no overflow write and no corruption.
- A branch at the boundary where an interrupt is taken: br_target is saved as the return address and the branch is not lost.
- NPC wraps: with PC=2^XLEN-1 and PC_STEP=1, NPC=0.
- int_active = (depth != 0), registered-derived with no combinational path from INT.

Optional Feature:
Macro INT_NEST_EN.
- Defined: interrupts nest. An interrupt may be taken whenever depth<STK_DEPTH.
- Undefined: an interrupt may be taken only when depth=0. Requests arriving while int_active=1 remain pending until the matching is_reti returns depth to 0. The stack is still STK_DEPTH deep, but depth never exceeds 1.

Test Plan:
- Reset and sequential:
  - Stimulus: rst=0, then release; updPC=1 for 3 cycles.
  - Required: PC=0 at reset, then 1, 2, 3. With updPC=0, PC holds at 3.
- Branch:
  - Stimulus: PC=5, isBranch=1, br_target=32'h40, updPC=1.
  - Required: PC=32'h40 next cycle, NPC=32'h41.
- Interrupt entry and return:
  - Stimulus: PC=8, INT pulse, updPC=1 every cycle.
  - Required: within 4 cycles PC=32'h100, int_ack pulses once, stk_depth=1, saved entry = PC+1 at that boundary.
  - Then: is_reti at a boundary restores that value, depth=0.
- Interrupt plus branch and stack full:
  - Stimulus: STK_DEPTH=2, INT_NEST_EN defined, three INT edges each serviced without reti; the first is taken at a boundary with isBranch=1, br_target=32'h80.
  - Required: stack[0]=32'h80, depth reaches 2, third request stays pending with no int_ack.
  - Then: one reti gives depth=1, and the third interrupt is taken at the following boundary.
- Reti and underflow:
  - Stimulus: is_reti at depth=0 with PC=10.
  - Required: PC=11, stk_unf=1, and stk_unf stays 1 until rst.
- No nesting and async reset:
  - Stimulus: INT_NEST_EN undefined; second INT while int_active=1.
  - Required: no int_ack until after reti returns depth to 0.
  - Then: assert rst mid-service; PC=RST_VEC, depth=0, pending cleared, all immediately without a clock.
